// File: rtl/dae_pkg.sv
// dae_pkg: shared constants and FSM encoding for the DAE layer sequencer.
// Optional build macro LEAKY_RELU_EN selects the leaky activation.
package dae_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;
  localparam int LEAKY_SHIFT = 3;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_MAC = 3'd2;
  localparam logic [2:0] ST_BIAS = 3'd3;
  localparam logic [2:0] ST_EMIT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_LOAD = ST_LOAD,
    S_MAC = ST_MAC,
    S_BIAS = ST_BIAS,
    S_EMIT = ST_EMIT
  } state_t;

endpackage

// File: rtl/dae_mac_act.sv
// dae_mac_act: signed MAC accumulator, bias add and saturating activation.
// LEAKY_RELU_EN: negatives become acc_b >>> LEAKY_SHIFT, else ReLU to 0.
module dae_mac_act
  import dae_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W = 20
) (
  input logic clk,
  input logic rst_n,
  input logic clear,
  input logic acc_en,
  input logic bias_en,
  input logic signed [DATA_W-1:0] x,
  input logic signed [DATA_W-1:0] w,
  input logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] act
);

  localparam int PW = 2 * DATA_W;
  localparam logic signed [DATA_W-1:0] SMAX =
    {1'b0, {(DATA_W-1){1'b1}}};

  logic signed [PW-1:0] xe;
  logic signed [PW-1:0] we;
  logic signed [PW-1:0] prod;
  logic signed [ACC_W-1:0] prod_x;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W:0] acc_b;
  logic neg;
  logic pos_ovf;
  logic signed [DATA_W-1:0] act_nxt;

  assign xe = {{DATA_W{x[DATA_W-1]}}, x};
  assign we = {{DATA_W{w[DATA_W-1]}}, w};
  assign prod = xe * we;
  assign prod_x = {{(ACC_W-PW){prod[PW-1]}}, prod};

  assign acc_b = {acc[ACC_W-1], acc}
               + {{(ACC_W+1-DATA_W){b[DATA_W-1]}}, b};
  assign neg = acc_b[ACC_W];
  assign pos_ovf = !neg && (|acc_b[ACC_W-1:DATA_W-1]);

`ifdef LEAKY_RELU_EN
  logic signed [ACC_W:0] sh;
  logic neg_ovf;
  localparam logic signed [DATA_W-1:0] SMIN =
    {1'b1, {(DATA_W-1){1'b0}}};

  assign sh = acc_b >>> LEAKY_SHIFT;
  assign neg_ovf = !(&sh[ACC_W:DATA_W-1]);
`endif

  // activation and saturation of the biased sum
  always_comb begin
    act_nxt = acc_b[DATA_W-1:0];
    unique case (1'b1)
      pos_ovf: act_nxt = SMAX;
`ifdef LEAKY_RELU_EN
      neg: act_nxt = neg_ovf ? SMIN : sh[DATA_W-1:0];
`else
      neg: act_nxt = '0;
`endif
      default: act_nxt = acc_b[DATA_W-1:0];
    endcase
  end

  // accumulator and registered activation output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      act <= '0;
    end else begin
      if (clear) begin
        acc <= '0;
      end else if (acc_en) begin
        acc <= acc + prod_x;
      end
      if (bias_en) begin
        act <= act_nxt;
      end
    end
  end

endmodule

// File: rtl/dae_layer_sequencer.sv
// dae_layer_sequencer: one dense DAE layer on a shared MAC/activation unit.
// Build macro LEAKY_RELU_EN selects leaky activation inside dae_mac_act.
module dae_layer_sequencer
  import dae_pkg::*;
#(
  parameter int N_IN = 16,
  parameter int N_OUT = 8,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W = 20,
  localparam int AW = $clog2(N_IN * N_OUT),
  localparam int IW = $clog2(N_IN),
  localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input logic clk,
  input logic rst_n,
  input logic in_valid,
  output logic in_ready,
  input logic signed [DATA_W-1:0] in_data,
  output logic [AW-1:0] w_addr,
  input logic signed [DATA_W-1:0] w_data,
  output logic [JW-1:0] b_addr,
  input logic signed [DATA_W-1:0] b_data,
  output logic out_valid,
  input logic out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [JW-1:0] out_idx,
  output logic busy
);

  state_t state;
  state_t state_nxt;
  logic [IW-1:0] i;
  logic [IW-1:0] i_d;
  logic [JW-1:0] j;
  logic drain;
  logic take;
  logic i_max;
  logic last;
  logic clear;
  logic acc_en;
  logic bias_en;
  logic signed [DATA_W-1:0] in_buf [N_IN];

  assign in_ready = (state == S_IDLE) || (state == S_LOAD);
  assign busy = !in_ready;
  assign out_valid = (state == S_EMIT);
  assign out_idx = j;
  assign b_addr = j;
  assign w_addr = AW'({j, i});

  assign take = in_valid && in_ready;
  assign i_max = (i == IW'(N_IN - 1));
  assign last = (j == JW'(N_OUT - 1));

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state and datapath strobes
  always_comb begin
    state_nxt = state;
    clear = 1'b0;
    acc_en = 1'b0;
    bias_en = 1'b0;
    unique case (state)
      S_IDLE, S_LOAD: begin
        if (take) begin
          state_nxt = S_LOAD;
          if (i_max) begin
            state_nxt = S_MAC;
            clear = 1'b1;
          end
        end
      end
      S_MAC: begin
        acc_en = (i != '0) || drain;
        if (drain) begin
          state_nxt = S_BIAS;
        end
      end
      S_BIAS: begin
        bias_en = 1'b1;
        state_nxt = S_EMIT;
      end
      S_EMIT: begin
        if (out_ready) begin
          if (last) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_MAC;
            clear = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // input/tap counter i, neuron counter j, drain flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i <= '0;
      i_d <= '0;
      j <= '0;
      drain <= 1'b0;
    end else begin
      i_d <= i;
      unique case (state)
        S_IDLE, S_LOAD: begin
          if (take) begin
            i <= i + IW'(1);
          end
        end
        S_MAC: begin
          if (drain) begin
            drain <= 1'b0;
          end else begin
            i <= i + IW'(1);
            drain <= i_max;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            j <= last ? '0 : j + JW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // input frame buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_IN; k++) begin
        in_buf[k] <= '0;
      end
    end else if (take) begin
      in_buf[i] <= in_data;
    end
  end

  dae_mac_act #(
    .DATA_W(DATA_W),
    .ACC_W(ACC_W)
  ) u_mac (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .acc_en(acc_en),
    .bias_en(bias_en),
    .x(in_buf[i_d]),
    .w(w_data),
    .b(b_data),
    .act(out_data)
  );

endmodule

// File: tb/tb_dae_layer_sequencer.sv
// tb_dae_layer_sequencer: table vectors, model frames and corner sequences.
// Expected activations follow LEAKY_RELU_EN when the bench is built with it.
module tb_dae_layer_sequencer;
  import dae_pkg::*;

  localparam int N_IN = 16;
  localparam int N_OUT = 8;
  localparam int DW = 8;
  localparam int AW = 7;
  localparam int JW = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic signed [DW-1:0] in_data;
  logic [AW-1:0] w_addr;
  logic signed [DW-1:0] w_data;
  logic [JW-1:0] b_addr;
  logic signed [DW-1:0] b_data;
  logic out_valid;
  logic out_ready;
  logic signed [DW-1:0] out_data;
  logic [JW-1:0] out_idx;
  logic busy;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  logic signed [DW-1:0] w_rom [N_IN*N_OUT];
  logic signed [DW-1:0] b_rom [N_OUT];
  logic signed [DW-1:0] frame [N_IN];

  typedef struct {
    int data;
    int idx;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int in_v;
    int w_v;
    int b_v;
    int e_relu;
    int e_leaky;
  } vec_t;
  vec_t vt[14];

  dae_layer_sequencer #(
    .N_IN(N_IN), .N_OUT(N_OUT), .DATA_W(DW), .ACC_W(20)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_addr(w_addr), .w_data(w_data),
    .b_addr(b_addr), .b_data(b_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // external ROMs with one-cycle read latency
  always @(posedge clk) begin
    w_data <= w_rom[w_addr];
    b_data <= b_rom[b_addr];
  end

  task automatic chk(input string nm, input int act, input int want);
    n_chk++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, want);
  endtask

  task automatic expired(input string nm);
    n_chk++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  function automatic int act_fn(input int s);
    if (s > SAT_MAX) return SAT_MAX;
    if (s >= 0) return s;
`ifdef LEAKY_RELU_EN
    if ((s >>> LEAKY_SHIFT) < SAT_MIN) return SAT_MIN;
    return s >>> LEAKY_SHIFT;
`else
    return 0;
`endif
  endfunction

  // scoreboard: compare every accepted activation
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL extra_out: got idx %0d data %0d expected none",
                 out_idx, out_data);
      end else begin
        e = sb.pop_front();
        chk("out_data", int'(out_data), e.data);
        chk("out_idx", int'(out_idx), e.idx);
      end
    end
  end

  task automatic model_push();
    int s;
    for (int j = 0; j < N_OUT; j++) begin
      s = int'(b_rom[j]);
      for (int k = 0; k < N_IN; k++)
        s += int'(frame[k]) * int'(w_rom[j*N_IN+k]);
      sb.push_back('{data: act_fn(s), idx: j});
    end
  endtask

  task automatic send_frame(output int lb);
    int n;
    lb = 0;
    @(posedge clk);
    #1;
    for (int k = 0; k < N_IN; k++) begin
      in_valid = 1'b1;
      in_data = frame[k];
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 1000) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) begin
        expired("in_ready");
        break;
      end
      @(posedge clk);
      #1;
      lb = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int k, output int c);
    int n = 0;
    c = 0;
    @(negedge clk);
    while (!(out_valid && (k < 0 || int'(out_idx) == k)) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) expired("out_valid");
    c = cyc;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || !in_ready) && n < 3000);
    if (sb.size() != 0 || !in_ready) begin
      expired(nm);
      sb.delete();
    end
  endtask

  task automatic check_reset(input string t);
    chk({t, "_in_ready"}, int'(in_ready), 1);
    chk({t, "_out_valid"}, int'(out_valid), 0);
    chk({t, "_out_data"}, int'(out_data), 0);
    chk({t, "_out_idx"}, int'(out_idx), 0);
    chk({t, "_w_addr"}, int'(w_addr), 0);
    chk({t, "_b_addr"}, int'(b_addr), 0);
    chk({t, "_busy"}, int'(busy), 0);
  endtask

  task automatic ramp_setup();
    for (int k = 0; k < N_IN; k++) frame[k] = 8'sd1;
    for (int a = 0; a < N_IN*N_OUT; a++) w_rom[a] = 8'sd1;
    for (int j = 0; j < N_OUT; j++) begin
      b_rom[j] = DW'(j);
      sb.push_back('{data: 16 + j, idx: j});
    end
  endtask

  task automatic rand_setup();
    for (int k = 0; k < N_IN; k++)
      frame[k] = DW'($urandom_range(40) - 20);
    for (int a = 0; a < N_IN*N_OUT; a++)
      w_rom[a] = DW'($urandom_range(8) - 4);
    for (int j = 0; j < N_OUT; j++)
      b_rom[j] = DW'($urandom_range(60) - 30);
    model_push();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lb;
    int c;
    int hs;
    int e;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    for (int a = 0; a < N_IN*N_OUT; a++) w_rom[a] = '0;
    for (int j = 0; j < N_OUT; j++) b_rom[j] = '0;

    vt[0] = '{1, 1, 0, 16, 16};
    vt[1] = '{127, 127, 127, 127, 127};
    vt[2] = '{1, -1, 0, 0, -2};
    vt[3] = '{1, 1, -20, 0, -1};
    vt[4] = '{1, 1, 5, 21, 21};
    vt[5] = '{4, 2, -1, 127, 127};
    vt[6] = '{4, 2, 0, 127, 127};
    vt[7] = '{1, 8, -2, 126, 126};
    vt[8] = '{-128, 127, 0, 0, -128};
    vt[9] = '{-128, -128, 127, 127, 127};
    vt[10] = '{1, -64, 0, 0, -128};
    vt[11] = '{1, -64, -8, 0, -128};
    vt[12] = '{1, -64, 8, 0, -127};
    vt[13] = '{2, -1, 0, 0, -4};

    #12;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[v]) begin
      for (int k = 0; k < N_IN; k++) frame[k] = DW'(vt[v].in_v);
      for (int a = 0; a < N_IN*N_OUT; a++) w_rom[a] = DW'(vt[v].w_v);
      for (int j = 0; j < N_OUT; j++) b_rom[j] = DW'(vt[v].b_v);
`ifdef LEAKY_RELU_EN
      e = vt[v].e_leaky;
`else
      e = vt[v].e_relu;
`endif
      for (int j = 0; j < N_OUT; j++) sb.push_back('{data: e, idx: j});
      send_frame(lb);
      if (v == 0) begin
        wait_out(-1, c);
        chk("first_latency", c - lb, N_IN + 2);
        hs = 0;
        while (!in_ready && hs < 1000) begin
          @(negedge clk);
          hs++;
        end
        chk("layer_latency", cyc - lb, N_OUT * (N_IN + 3));
      end
      wait_idle("drain_vec");
    end

    for (int r = 0; r < 2; r++) begin
      rand_setup();
      send_frame(lb);
      wait_idle("drain_rand");
    end

    // backpressure on neuron 3 with upstream pushing while busy
    ramp_setup();
    send_frame(lb);
    wait_out(2, c);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'sd55;
    wait_out(3, c);
    for (int t = 0; t < 5; t++) begin
      if (t > 0) @(negedge clk);
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_idx", int'(out_idx), 3);
      chk("hold_data", int'(out_data), 19);
      chk("hold_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    hs = cyc;
    wait_out(4, c);
    chk("next_neuron_start", c - hs, N_IN + 3);
    wait_idle("drain_bp");

    // asynchronous reset in the middle of neuron 2
    ramp_setup();
    send_frame(lb);
    wait_out(1, c);
    @(posedge clk);
    #1;
    repeat (5) @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    chk("mid_w_addr", int'(w_addr), 2 * N_IN + 4);
    chk("mid_b_addr", int'(b_addr), 2);
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rand_setup();
    send_frame(lb);
    wait_idle("drain_after_rst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
